multicycle_sequencer: RTL and testbench

Multicycle control FSM for the processor datapath. It fetches one 32-bit instruction per pass over an instruction-memory handshake and decodes opcode `[31:26]` and funct `[5:0]`. It then steps the datapath through EXEC/MEM/WB, raising per-state strobes. It sits between the instruction/data memory ports and the register file/ALU, and supersedes per-cycle decoding with a sequenced, stall-aware control flow.

---
 rtl/multicycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle control FSM sequencing fetch/decode/exec/mem/wb with handshakes.
// Outputs are Moore from state and IR, except ir_load/pc_en which follow imem_ack in FETCH.
module multicycle_sequencer #(
    parameter logic [5:0] OP_RTYPE   = 6'b000100,
    parameter logic [5:0] OP_LW      = 6'b000101,
    parameter logic [5:0] OP_SW      = 6'b000110,
    parameter int         MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        dmem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] retired_q, retired_d;

    logic [5:0] opc, fn;
    logic       is_r, is_lw, is_sw, is_mul, r_ok, legal;
    logic [2:0] r_op;
    logic       unused_ir;

    assign opc       = ir_q[31:26];
    assign fn        = ir_q[5:0];
    assign unused_ir = ^ir_q[25:6];
    assign is_r      = opc == OP_RTYPE;
    assign is_lw     = opc == OP_LW;
    assign is_sw     = opc == OP_SW;
    assign is_mul    = is_r && fn == 6'b110010;
    assign legal     = (is_r && r_ok) || is_lw || is_sw;

    always_comb begin
        r_ok = 1'b1;
        r_op = ALU_ADD;
        case (fn)
            6'b100000: r_op = 3'b000;
            6'b100010: r_op = 3'b001;
            6'b100100: r_op = 3'b010;
            6'b100101: r_op = 3'b011;
            6'b110010: r_op = 3'b100;
            default:   r_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // qualified by rst_n so every output is 0 while reset is held
                imem_req = rst_n;
                ir_load  = rst_n && imem_ack;
                pc_en    = rst_n && imem_ack;
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d   = '0;
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_op  = is_r ? r_op : ALU_ADD;
                alu_src = is_lw || is_sw;
                if (is_mul && cnt_q != MUL_LAST)
                    cnt_d = cnt_q + 4'd1;
                else
                    state_d = is_r ? S_WB : S_MEM;
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                alu_src   = 1'b1;
                if (dmem_ack) begin
                    state_d   = is_lw ? S_WB : S_FETCH;
                    retired_d = is_sw ? retired_q + 16'd1 : retired_q;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                retired_d  = retired_q + 16'd1;
                state_d    = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed table, hand sequences and random instructions against a phase-list model.
module tb_multicycle_sequencer;
    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, ir_load, pc_en, alu_src, dmem_req, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [2:0]  alu_op, state;
    logic [15:0] retired;
    logic [16:0] ov;

    int          checks = 0, errors = 0;
    logic [15:0] exp_ret = '0;

    multicycle_sequencer #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .alu_op(alu_op), .alu_src(alu_src),
        .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    assign ov = {state, imem_req, ir_load, pc_en, alu_op, alu_src, dmem_req,
                 mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] v(input logic [2:0] st, input bit req, input bit ld,
                                      input logic [2:0] alu, input bit src, input bit dreq,
                                      input bit rd, input bit wr, input bit rw, input bit rdst,
                                      input bit m2r, input bit ill);
        return {st, req, ld, ld, alu, src, dreq, rd, wr, rw, rdst, m2r, ill};
    endfunction

    // kind: 0 illegal, 1 R-type (non-MUL), 2 LW, 3 SW, 4 MUL
    function automatic void classify(input logic [31:0] i, output int kind, output logic [2:0] alu);
        kind = 0;
        alu  = 3'd0;
        case (i[31:26])
            6'b000101: kind = 2;
            6'b000110: kind = 3;
            6'b000100:
                case (i[5:0])
                    6'h20: kind = 1;
                    6'h22: begin kind = 1; alu = 3'd1; end
                    6'h24: begin kind = 1; alu = 3'd2; end
                    6'h25: begin kind = 1; alu = 3'd3; end
                    6'h32: begin kind = 4; alu = 3'd4; end
                    default: kind = 0;
                endcase
            default: kind = 0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", ov, 0);
        chk("reset_retired", retired, 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_outputs", ov, 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("first_req", ov, v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_ret = '0;
    endtask

    // Expected per-cycle outputs are laid out as a list of phases; acks react to the DUT's state.
    task automatic run(input logic [31:0] ins, input int fw, input int mw, input int exp_cyc,
                       input logic [2:0] exp_alu, input bit tbl, input bit noise);
        logic [16:0] q[$];
        int          kind, cyc, fc, mc;
        logic [2:0]  alu, alu_seen, st;
        bit          left, done, memop;
        classify(ins, kind, alu);
        memop = kind == 2 || kind == 3;
        for (int i = 0; i < fw; i++) q.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (kind == 0) begin
            repeat (20) q.push_back(v(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            repeat (kind == 4 ? MC : 1) q.push_back(v(2, 0, 0, alu, memop, 0, 0, 0, 0, 0, 0, 0));
            if (memop) repeat (mw + 1) q.push_back(v(3, 0, 0, 0, 1, 1, kind == 2, kind == 3, 0, 0, 0, 0));
            if (kind != 3) q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, kind == 1 || kind == 4, kind == 2, 0));
        end
        cyc = 0; fc = 0; mc = 0; left = 0; done = 0; alu_seen = 3'd7;
        while (!done && cyc < 80) begin
            st       = state;
            imem_ack = (st == 3'd0) ? (fc == fw) : (noise ? 1'($urandom) : 1'b0);
            dmem_ack = (st == 3'd3) ? (mc == mw) : (noise ? 1'($urandom) : 1'b0);
            instr    = (st == 3'd0) ? ins : $urandom;
            @(negedge clk);
            if (cyc < q.size()) begin
                chk($sformatf("outputs %08h c%0d", ins, cyc), ov, q[cyc]);
            end else begin
                chk($sformatf("overrun %08h", ins), cyc, q.size());
                done = 1;
            end
            chk($sformatf("retired_hold %08h c%0d", ins, cyc), retired, exp_ret);
            if (state == 3'd2) alu_seen = alu_op;
            if (state == 3'd0) fc++;
            if (state == 3'd3) mc++;
            if (state != 3'd0) left = 1;
            cyc++;
            @(posedge clk);
            #1;
            if (kind != 0 && left && state == 3'd0) done = 1;
            if (kind == 0 && cyc == q.size()) done = 1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk($sformatf("cycles %08h", ins), cyc, q.size());
        if (tbl) begin
            chk($sformatf("table_cycles %08h", ins), cyc, exp_cyc);
            chk($sformatf("table_alu %08h", ins), alu_seen, exp_alu);
        end
        if (kind == 0) begin
            chk("trap_state", state, 5);
            chk("trap_illegal", illegal, 1);
            do_reset();
            chk("trap_cleared", illegal, 0);
        end else begin
            exp_ret = exp_ret + 16'd1;
            chk($sformatf("retire %08h", ins), retired, exp_ret);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h32};
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 6)       return {6'b000100, r[25:6], fns[$urandom_range(0, 4)]};
        else if (sel < 9)  return {6'b000101, r[25:0]};
        else if (sel < 12) return {6'b000110, r[25:0]};
        else if (sel == 12) return {6'b000100, r[25:0]};
        else if (sel == 13) return r;
        return {6'b000100, r[25:6], fns[4]};
    endfunction

    typedef struct {
        logic [31:0] ins;
        int          fw;
        int          mw;
        int          cyc;
        logic [2:0]  alu;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{32'h10011520, 0, 0, 4, 3'd0};
        tbl[1] = '{32'h14013000, 0, 2, 7, 3'd0};
        tbl[2] = '{32'h18010000, 0, 0, 4, 3'd0};
        tbl[3] = '{32'h10011532, 0, 0, 7, 3'd4};
        tbl[4] = '{32'h10011522, 0, 0, 4, 3'd1};
        tbl[5] = '{32'h10011524, 0, 0, 4, 3'd2};
        tbl[6] = '{32'h10011525, 0, 0, 4, 3'd3};
        tbl[7] = '{32'h14013000, 3, 1, 9, 3'd0};
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) do_reset();
            run(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].cyc, tbl[i].alu, 1'b1, 1'b0);
            if (i == 6) chk("retired_mul_sub_and_or", retired, 4);
        end
        chk("retired_after_table", retired, 5);

        // illegal funct under R-type opcode: 20 trap cycles with imem_req low, then reset
        run(32'h10011500, 0, 0, 0, 3'd0, 1'b0, 1'b1);
        chk("retired_after_trap", retired, 0);

        // reset during a LW memory wait aborts with no retire and no reg_write
        run(32'h10011520, 0, 0, 0, 3'd0, 1'b0, 1'b0);
        instr    = 32'h14013000;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("lw_wait_state", state, 3);
        chk("lw_wait_read", mem_read, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", ov, 0);
        chk("abort_retired", retired, 0);
        dmem_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; chk("abort_no_wb", ov, 0); end
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("restart_fetch", ov, v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_ret = '0;
        run(32'h10011520, 0, 0, 0, 3'd0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++)
            run(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 0, 3'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
